// File: rtl/checkpoint_queue_if.sv
// checkpoint_queue_if
// Bundles the rename/branch-resolution handshake and the checkpoint RAM
// port of checkpoint_queue.
//   slave  : the queue controller (consumes requests, drives the RAM port)
//   master : the surrounding logic / testbench
// Signals:
//   alloc_valid/alloc_data/alloc_ready/alloc_id   checkpoint allocation
//   commit_valid                                  retire oldest entry
//   restore_valid/restore_id/restore_ready        mispredict restore request
//   restore_data_valid/restore_data               restored snapshot
//   ram_addr/ram_we/ram_din/ram_dout              shared-address RAM port
//   count/empty/full                              occupancy
interface checkpoint_queue_if #(
    parameter int WIDTH = 605,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             alloc_valid;
    logic [WIDTH-1:0] alloc_data;
    logic             alloc_ready;
    logic [AW-1:0]    alloc_id;
    logic             commit_valid;
    logic             restore_valid;
    logic [AW-1:0]    restore_id;
    logic             restore_ready;
    logic             restore_data_valid;
    logic [WIDTH-1:0] restore_data;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;
    logic [AW:0]      count;
    logic             empty;
    logic             full;

    modport slave (
        input  alloc_valid, alloc_data, commit_valid, restore_valid, restore_id, ram_dout,
        output alloc_ready, alloc_id, restore_ready, restore_data_valid, restore_data,
               ram_addr, ram_we, ram_din, count, empty, full
    );

    modport master (
        output alloc_valid, alloc_data, commit_valid, restore_valid, restore_id, ram_dout,
        input  alloc_ready, alloc_id, restore_ready, restore_data_valid, restore_data,
               ram_addr, ram_we, ram_din, count, empty, full
    );
endinterface

// File: rtl/checkpoint_queue.sv
// checkpoint_queue
// Circular-queue controller for a DEPTH-entry rename-map checkpoint RAM.
// Rename allocates one checkpoint per branch at the tail, commit retires the
// head, and a mispredict restore reads one checkpoint back and frees it plus
// every younger entry by pulling the tail back to the restored tag.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  checkpoint_queue_if.slave (handshakes, RAM port, occupancy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting alloc / restore / commit
// RESTORE | one cycle: restore_data valid, alloc and restore blocked
module checkpoint_queue #(
    parameter int WIDTH = 605,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    checkpoint_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t           state;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count_q;
    logic             rdv_q;
    logic [WIDTH-1:0] rdata_q;

    logic             full_w;
    logic             alloc_ready_w;
    logic             restore_ready_w;
    logic             alloc_acc;
    logic             restore_acc;
    logic             commit_acc;
    logic [AW-1:0]    restore_span;
    logic [AW:0]      count_nxt;

    always_comb begin
        full_w          = (count_q == FULL_COUNT);
        restore_ready_w = (state == IDLE);
        // Restore wins over alloc, so a pending restore blocks alloc_ready.
        alloc_ready_w   = !full_w && (state == IDLE) && !bus.restore_valid;
        alloc_acc       = bus.alloc_valid && alloc_ready_w;
        restore_acc     = bus.restore_valid && restore_ready_w && (count_q != '0);
        commit_acc      = bus.commit_valid && (count_q != '0);
        // Entries older than the restored tag survive: distance from head.
        restore_span    = bus.restore_id - head;
        count_nxt       = count_q;
        if (restore_acc) begin
            count_nxt = {1'b0, restore_span} - (AW+1)'(commit_acc);
        end else begin
            count_nxt = count_q + (AW+1)'(alloc_acc) - (AW+1)'(commit_acc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            head    <= head + AW'(commit_acc);
            tail    <= restore_acc ? bus.restore_id : tail + AW'(alloc_acc);
            count_q <= count_nxt;
            rdv_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (restore_acc) begin
                        state   <= RESTORE;
                        rdv_q   <= 1'b1;
                        rdata_q <= bus.ram_dout;
                    end
                end
                RESTORE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alloc_ready        = alloc_ready_w;
    assign bus.alloc_id           = tail;
    assign bus.restore_ready      = restore_ready_w;
    assign bus.restore_data_valid = rdv_q;
    assign bus.restore_data       = rdata_q;
    assign bus.ram_addr           = restore_acc ? bus.restore_id : tail;
    assign bus.ram_we             = alloc_acc;
    assign bus.ram_din            = bus.alloc_data;
    assign bus.count              = count_q;
    assign bus.empty              = (count_q == '0);
    assign bus.full               = full_w;

    // Restoring a tag outside [head, tail) or restoring the entry being
    // committed in the same cycle corrupts the occupancy count.
    a_restore_in_range: assert property (@(posedge clk) disable iff (rst)
        restore_acc |-> ({1'b0, restore_span} < count_q));
    a_restore_not_committed: assert property (@(posedge clk) disable iff (rst)
        (restore_acc && commit_acc) |-> (bus.restore_id != head));
endmodule
